mul_resp_tracker: RTL and testbench
===================================

Name: mul_resp_tracker

Overview:
Issue-side companion to the fixed-latency pipelined integer multiplier, which has no ready, tag or response valid. Accepts multiply micro-ops over a valid/ready handshake and drives the multiplier request. A LATENCY-deep shift register carries valid and tag alongside each op in flight. Each returning result is captured into a writeback FIFO with its tag and drained over a valid/ready writeback port; credit-based issue throttling guarantees the FIFO never overflows.

Parameters:
LATENCY, 3, cycles from multiplier request-valid cycle to the cycle its result appears on mul_resp_data (>=1)
TAG_W, 6, width of the op tag (ROB index)
XLEN, 64, data width
FIFO_DEPTH, 5, writeback FIFO entries and total credit count; LATENCY+2 sustains one op per cycle

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
iss_valid  in  1  op offered
iss_ready  out  1  op can be accepted this cycle
iss_fn  in  4  multiplier function code
iss_dw  in  1  1 = 64-bit op, 0 = 32-bit op
iss_in1  in  XLEN  operand 1
iss_in2  in  XLEN  operand 2
iss_tag  in  TAG_W  op tag
mul_req_valid  out  1  request to the multiplier
mul_req_fn  out  4  pass-through of iss_fn
mul_req_dw  out  1  pass-through of iss_dw
mul_req_in1  out  XLEN  pass-through of iss_in1
mul_req_in2  out  XLEN  pass-through of iss_in2
mul_resp_data  in  XLEN  multiplier result
flush  in  1  kill every op in flight and every buffered result
wb_valid  out  1  result available
wb_ready  in  1  consumer takes the result
wb_tag  out  TAG_W  tag of the head result
wb_data  out  XLEN  head result

Behaviour:
- Reset: shift-register valid bits cleared, FIFO empty, credit count 0; wb_valid=0, mul_req_valid=0, iss_ready=0 while reset is high. iss_ready=1 in the first cycle after reset.
- outstanding = in-flight valid count + FIFO count, held in a registered counter.
- iss_ready = !reset & !flush & (outstanding < FIFO_DEPTH).
  - Does not depend on the same-cycle wb pop.
  - No combinational path from wb_ready to iss_ready.
- Accept: iss_valid & iss_ready.
  - mul_req_valid = accept, combinational, same cycle.
  - mul_req_fn/dw/in1/in2 are direct wires from the iss_* inputs.
- Shift register: stage 0 captures {accept, iss_tag} at the clock edge. Each stage advances by one every cycle, unconditionally.
  - An op accepted in cycle t occupies stage LATENCY-1 in cycle t+LATENCY.
  - In that cycle mul_resp_data is its result; if the stage is valid, push {tag, mul_resp_data} into the FIFO.
- FIFO: circular buffer with head/tail pointers modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
  - No bypass: a result pushed in cycle t+LATENCY gives wb_valid no earlier than t+LATENCY+1.
  - wb_valid = FIFO non-empty; wb_tag/wb_data = head entry.
  - Pop on wb_valid & wb_ready.
  - Simultaneous push and pop: count unchanged, pointers both advance.
- Credit update: outstanding += accept, -= pop.
  - A push is neutral: the op moves from in flight to the FIFO.
  - Full latency with wb_ready=1 is LATENCY+1 from issue to wb_valid.
- Flush (registered effect): at the clock edge, all stage valids clear, FIFO pointers and count reset, outstanding resets to 0.
  - In the flush cycle, iss_ready=0, so no accept.
  - A pop in the flush cycle is allowed on the wire but has no additional effect.
  - A push in the flush cycle is discarded.
  - Multiplier results of flushed ops arrive against cleared valids and are ignored.
- Ordering: results leave strictly in issue order.
- Assertions:
  - No push when the FIFO is full.
  - outstanding never exceeds FIFO_DEPTH.
  - wb_tag/wb_data stable while wb_valid & !wb_ready.
- Reset mid-operation has the same effect as flush, plus wb_valid forced to 0.

Decomposition:
- Package mul_trk_pkg holds:
  - XLEN and TAG_W defaults.
  - Function codes: FN_MUL=4'd0, FN_MULH=4'd1, FN_MULHSU=4'd2, FN_MULHU=4'd3.
  - The writeback entry struct {tag, data}.
- Sub-module mul_wb_fifo: parameterised synchronous FIFO with a clear input, driven by flush|reset, and a count output. The tracker top holds the shift register and credit counter.

Test Plan:
- After reset, issue MUL dw=1 in1=3 in2=5 tag=7 in cycle 10, wb_ready=1 -> mul_req_valid=1 in cycle 10; wb_valid=1, wb_tag=7, wb_data=15 only in cycle 14.
- Issue tags 0..9 back-to-back with wb_ready=1 -> iss_ready never drops; wb_tag=0..9 in consecutive cycles starting 4 cycles after first issue.
- wb_ready=0, iss_valid held high -> exactly 5 ops accepted, then iss_ready=0. Raise wb_ready -> one pop per cycle; iss_ready returns the cycle after the first pop; no tag lost or duplicated.
- Two ops in flight (tags 3,4) plus one buffered (tag 2), flush pulsed -> no wb_valid for tags 2/3/4. iss_ready=1 next cycle, outstanding=0; late mul_resp_data values are not pushed.
- flush and iss_valid in the same cycle -> iss_ready=0, mul_req_valid=0, no writeback ever for that op.
- Reset asserted with 3 ops in flight -> wb_valid=0 during reset and afterwards until a new issue; the first post-reset op (tag 1, 2*2) writes back 4.

Source files
------------

// File: rtl/mul_trk_pkg.sv
// Shared defaults, multiplier function codes and the writeback entry layout
// for the multiplier response tracker.
package mul_trk_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int TAG_W_DEF = 6;

  localparam logic [3:0] FN_MUL    = 4'd0;
  localparam logic [3:0] FN_MULH   = 4'd1;
  localparam logic [3:0] FN_MULHSU = 4'd2;
  localparam logic [3:0] FN_MULHU  = 4'd3;

  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/mul_wb_fifo.sv
// Circular-buffer writeback FIFO with a synchronous clear and occupancy count.
// The head entry is visible combinationally; a push is never bypassed to the head.
module mul_wb_fifo #(
  parameter int WIDTH = 70,
  parameter int DEPTH = 5,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop & (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push)   tail_d = wrap_inc(tail_q);
      if (do_pop) head_d = wrap_inc(head_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

  always_ff @(posedge clock) begin
    if (push && !clear) mem_q[tail_q] <= push_data;
  end

  assign valid     = (count_q != '0);
  assign head_data = mem_q[head_q];
  assign count     = count_q;

  a_no_overflow: assert property (@(posedge clock) disable iff (clear)
    !(push && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/mul_resp_tracker.sv
// Issue-side tracker for a fixed-latency multiplier: tags ride a shift register
// beside each op, results land in a credit-protected writeback FIFO.
module mul_resp_tracker
  import mul_trk_pkg::*;
#(
  parameter int LATENCY    = 3,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int XLEN       = XLEN_DEF,
  parameter int FIFO_DEPTH = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [3:0]       iss_fn,
  input  logic             iss_dw,
  input  logic [XLEN-1:0]  iss_in1,
  input  logic [XLEN-1:0]  iss_in2,
  input  logic [TAG_W-1:0] iss_tag,
  output logic             mul_req_valid,
  output logic [3:0]       mul_req_fn,
  output logic             mul_req_dw,
  output logic [XLEN-1:0]  mul_req_in1,
  output logic [XLEN-1:0]  mul_req_in2,
  input  logic [XLEN-1:0]  mul_resp_data,
  input  logic             flush,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [XLEN-1:0]  wb_data
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                            clear, accept, push, pop, fifo_valid;
  logic [LATENCY-1:0]              vld_q, vld_d;
  logic [LATENCY-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [CNT_W-1:0]                outstanding_q, outstanding_d;
  logic [CNT_W-1:0]                fifo_count;
  logic [TAG_W+XLEN-1:0]           fifo_head;

  assign clear = flush | reset;

  // Credits cover both in-flight ops and buffered results, so ready never
  // needs to look at the same-cycle writeback handshake.
  assign iss_ready = !reset && !flush && (outstanding_q < CNT_W'(FIFO_DEPTH));
  assign accept    = iss_valid & iss_ready;

  assign mul_req_valid = accept;
  assign mul_req_fn    = iss_fn;
  assign mul_req_dw    = iss_dw;
  assign mul_req_in1   = iss_in1;
  assign mul_req_in2   = iss_in2;

  assign vld_d[0] = accept;
  assign tag_d[0] = iss_tag;

  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_stage
      assign vld_d[gi] = vld_q[gi-1];
      assign tag_d[gi] = tag_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (clear) vld_q <= '0;
    else       vld_q <= vld_d;
    tag_q <= tag_d;
  end

  assign push = vld_q[LATENCY-1] & !flush;
  assign pop  = wb_valid & wb_ready;

  assign outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(pop);

  always_ff @(posedge clock) begin
    if (clear) outstanding_q <= '0;
    else       outstanding_q <= outstanding_d;
  end

  mul_wb_fifo #(
    .WIDTH (TAG_W + XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .clear     (clear),
    .push      (push),
    .push_data ({tag_q[LATENCY-1], mul_resp_data}),
    .pop       (pop),
    .valid     (fifo_valid),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign wb_valid          = fifo_valid & !reset;
  assign {wb_tag, wb_data} = fifo_head;

  a_credit_bound: assert property (@(posedge clock) disable iff (reset)
    outstanding_q <= CNT_W'(FIFO_DEPTH) && fifo_count <= outstanding_q);

  a_wb_stable: assert property (@(posedge clock) disable iff (reset)
    (wb_valid && !wb_ready && !flush) |=> ($stable(wb_tag) && $stable(wb_data)));

endmodule

// File: tb/tb_mul_resp_tracker.sv
// Directed bench for mul_resp_tracker with a behavioural 3-cycle multiplier model.
module tb_mul_resp_tracker;
  import mul_trk_pkg::*;

  localparam int LAT = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        iss_valid, iss_ready, iss_dw, flush, wb_valid, wb_ready;
  logic [3:0]  iss_fn;
  logic [63:0] iss_in1, iss_in2;
  logic [5:0]  iss_tag, wb_tag;
  logic        mul_req_valid, mul_req_dw;
  logic [3:0]  mul_req_fn;
  logic [63:0] mul_req_in1, mul_req_in2, mul_resp_data, wb_data;

  logic [63:0] pipe [LAT];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          got_tag [$];
  logic [63:0] got_data [$];
  int          got_cyc [$];

  mul_resp_tracker dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_fn(iss_fn), .iss_dw(iss_dw),
    .iss_in1(iss_in1), .iss_in2(iss_in2), .iss_tag(iss_tag),
    .mul_req_valid(mul_req_valid), .mul_req_fn(mul_req_fn), .mul_req_dw(mul_req_dw),
    .mul_req_in1(mul_req_in1), .mul_req_in2(mul_req_in2),
    .mul_resp_data(mul_resp_data), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  // Multiplier model: result appears LAT cycles after the request cycle.
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clock) begin
    pipe[0] <= mul_req_in1 * mul_req_in2;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_resp_data = pipe[LAT-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic step();
    #1;
    if (mul_req_valid) $display("cyc %0d issue tag=%0d in1=%0d in2=%0d", cyc, iss_tag, mul_req_in1, mul_req_in2);
    if (wb_valid && wb_ready) begin
      $display("cyc %0d wb tag=%0d data=%0d", cyc, wb_tag, wb_data);
      got_tag.push_back(int'(wb_tag));
      got_data.push_back(wb_data);
      got_cyc.push_back(cyc);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    got_tag.delete();
    got_data.delete();
    got_cyc.delete();
  endtask

  task automatic issue(input int tag, input int a, input int b);
    iss_valid = 1'b1;
    iss_fn    = FN_MUL;
    iss_dw    = 1'b1;
    iss_tag   = 6'(tag);
    iss_in1   = 64'(a);
    iss_in2   = 64'(b);
  endtask

  // Stall the consumer with issue held high, then drain and check order.
  task automatic stall_fill(input int base);
    int nacc;
    int tp;
    clear_log();
    wb_ready = 1'b0;
    nacc = 0;
    for (int k = 0; k < 8; k++) begin
      issue(base + nacc, base + nacc, 2);
      settle();
      if (iss_ready) nacc++;
      if (k == 7) begin
        check("stall_wb_valid", wb_valid, 1);
        check("stall_head_tag", wb_tag, base);
      end
      step();
    end
    check("stall_accepts", nacc, 5);
    iss_valid = 1'b0;
    wb_ready  = 1'b1;
    settle();
    check("drain_ready_first_pop", iss_ready, 0);
    tp = cyc;
    step();
    settle();
    check("drain_ready_after_pop", iss_ready, 1);
    repeat (6) step();
    check("drain_count", got_tag.size(), 5);
    for (int i = 0; i < got_tag.size() && i < 5; i++) begin
      check("drain_tag", got_tag[i], base + i);
      check("drain_data", got_data[i], (base + i) * 2);
      check("drain_cyc", got_cyc[i], tp + i);
    end
  endtask

  initial begin
    int t0;
    reset = 1'b1; flush = 1'b0; wb_ready = 1'b1;
    iss_valid = 1'b1; iss_fn = FN_MUL; iss_dw = 1'b1;
    iss_in1 = '0; iss_in2 = '0; iss_tag = '0;
    repeat (3) @(posedge clock);
    #1;
    settle();
    check("reset_iss_ready", iss_ready, 0);
    check("reset_wb_valid", wb_valid, 0);
    check("reset_req_valid", mul_req_valid, 0);
    step();
    reset = 1'b0;
    iss_valid = 1'b0;
    settle();
    check("post_reset_ready", iss_ready, 1);
    repeat (3) step();

    // Single op, full latency.
    clear_log();
    issue(7, 3, 5);
    settle();
    check("t1_req_valid", mul_req_valid, 1);
    check("t1_req_in1", mul_req_in1, 3);
    check("t1_req_in2", mul_req_in2, 5);
    check("t1_req_fn", mul_req_fn, FN_MUL);
    check("t1_req_dw", mul_req_dw, 1);
    t0 = cyc;
    step();
    iss_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      settle();
      check("t1_wb_valid", wb_valid, (k == 4));
      if (k == 4) begin
        check("t1_wb_tag", wb_tag, 7);
        check("t1_wb_data", wb_data, 15);
      end
      step();
    end

    // Back-to-back stream.
    clear_log();
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      issue(i, i, i + 1);
      settle();
      check("t2_ready", iss_ready, 1);
      step();
    end
    iss_valid = 1'b0;
    repeat (6) step();
    check("t2_count", got_tag.size(), 10);
    for (int i = 0; i < got_tag.size() && i < 10; i++) begin
      check("t2_tag", got_tag[i], i);
      check("t2_data", got_data[i], i * (i + 1));
      check("t2_cyc", got_cyc[i], t0 + 4 + i);
    end

    // Credit exhaustion.
    stall_fill(10);

    // Flush with one buffered and two in flight.
    clear_log();
    wb_ready = 1'b0;
    issue(2, 2, 3); step();
    iss_valid = 1'b0; step();
    issue(3, 4, 5); step();
    issue(4, 6, 7); step();
    iss_valid = 1'b0;
    flush = 1'b1;
    settle();
    check("fl_ready_in_flush", iss_ready, 0);
    step();
    flush = 1'b0;
    wb_ready = 1'b1;
    settle();
    check("fl_ready_after", iss_ready, 1);
    check("fl_wb_valid_after", wb_valid, 0);
    repeat (6) step();
    check("fl_no_writeback", got_tag.size(), 0);

    // Flush colliding with an issue attempt.
    clear_log();
    flush = 1'b1;
    issue(9, 6, 7);
    settle();
    check("fl_iss_ready", iss_ready, 0);
    check("fl_req_valid", mul_req_valid, 0);
    step();
    flush = 1'b0;
    iss_valid = 1'b0;
    repeat (6) step();
    check("fl_issue_dropped", got_tag.size(), 0);

    // Full credit pool after flushes.
    stall_fill(40);

    // Reset with three ops in flight.
    clear_log();
    wb_ready = 1'b1;
    issue(20, 1, 1); step();
    issue(21, 1, 2); step();
    issue(22, 1, 3); step();
    iss_valid = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("rst_wb_valid", wb_valid, 0);
      check("rst_iss_ready", iss_ready, 0);
      step();
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      check("rst_idle_wb_valid", wb_valid, 0);
      step();
    end
    check("rst_no_writeback", got_tag.size(), 0);
    issue(1, 2, 2);
    t0 = cyc;
    step();
    iss_valid = 1'b0;
    repeat (6) step();
    check("rst_new_count", got_tag.size(), 1);
    if (got_tag.size() > 0) begin
      check("rst_new_tag", got_tag[0], 1);
      check("rst_new_data", got_data[0], 4);
      check("rst_new_cyc", got_cyc[0], t0 + 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
